// File: rtl/fetch_decode_queue.sv
// Multi-lane fetch-to-decode instruction FIFO: per-lane PCs, group enqueue, in-order group dequeue.
// Optional same-cycle empty-queue bypass when FETCH_Q_BYPASS_EN is defined.

module fdq_in_lane #(
  parameter int IW    = 32,
  parameter int PW    = 64,
  parameter int PTR_W = 4,
  parameter int FC_W  = 3,
  parameter int LANE  = 0
) (
  input  logic             fire,
  input  logic [FC_W-1:0]  n_push,
  input  logic [FC_W-1:0]  wr_skip,
  input  logic [PTR_W-1:0] tail,
  input  logic [PW-1:0]    pc_base,
  output logic             we,
  output logic [PTR_W-1:0] waddr,
  output logic [PW-1:0]    pc
);
  localparam logic [FC_W-1:0] LANE_C = FC_W'(LANE);

  // Lanes consumed by the bypass are skipped; the rest pack down onto tail.
  assign we    = fire && (LANE_C < n_push) && (LANE_C >= wr_skip);
  assign waddr = tail + PTR_W'(LANE) - PTR_W'(wr_skip);
  assign pc    = pc_base + PW'(4 * LANE);
endmodule

module fetch_decode_queue #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int IN_WIDTH          = 4,
  parameter int OUT_WIDTH         = 4,
  parameter int DEPTH             = 16,
  parameter int PC_WIDTH          = 64
) (
  input  logic                                  clk_in,
  input  logic                                  rst_N_in,
  input  logic                                  flush_in,
  input  logic                                  fetch_valid_in,
  input  logic [$clog2(IN_WIDTH+1)-1:0]         fetch_count_in,
  input  logic [IN_WIDTH*INSTRUCTION_WIDTH-1:0] fetch_instrs_in,
  input  logic [PC_WIDTH-1:0]                   fetch_pc_in,
  output logic                                  fetch_ready_out,
  input  logic                                  decode_ready_in,
  output logic                                  decode_valid_out,
  output logic [$clog2(OUT_WIDTH+1)-1:0]        decode_count_out,
  output logic [OUT_WIDTH*INSTRUCTION_WIDTH-1:0] decode_instrs_out,
  output logic [OUT_WIDTH*PC_WIDTH-1:0]         decode_pcs_out,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy_out
);
  localparam int IW    = INSTRUCTION_WIDTH;
  localparam int PW    = PC_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int FC_W  = $clog2(IN_WIDTH+1);
  localparam int DC_W  = $clog2(OUT_WIDTH+1);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } entry_t;

  entry_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ;

  logic [FC_W-1:0] n_push, wr_skip, n_wr;
  logic [DC_W-1:0] q_cnt, byp_cnt, n_pop;
  logic            push_fire, byp_act, byp_pop;

  logic [IN_WIDTH-1:0]            lane_we;
  logic [IN_WIDTH-1:0][PTR_W-1:0] lane_addr;
  logic [IN_WIDTH-1:0][PW-1:0]    lane_pc;
  entry_t [OUT_WIDTH-1:0]         slot;

  assign fetch_ready_out = (occ <= OCC_W'(DEPTH - IN_WIDTH));
  assign push_fire       = fetch_valid_in & fetch_ready_out & ~flush_in;
  assign n_push          = (int'(fetch_count_in) > IN_WIDTH) ? FC_W'(IN_WIDTH) : fetch_count_in;
  assign q_cnt           = (int'(occ) > OUT_WIDTH) ? DC_W'(OUT_WIDTH) : DC_W'(occ);

`ifdef FETCH_Q_BYPASS_EN
  assign byp_act = (occ == '0) & push_fire;
  assign byp_cnt = (int'(n_push) > OUT_WIDTH) ? DC_W'(OUT_WIDTH) : DC_W'(n_push);
`else
  assign byp_act = 1'b0;
  assign byp_cnt = '0;
`endif

  assign decode_count_out = byp_act ? byp_cnt : q_cnt;
  assign decode_valid_out = (decode_count_out != '0) & ~flush_in;
  assign byp_pop          = byp_act & decode_ready_in;
  assign wr_skip          = byp_pop ? FC_W'(byp_cnt) : '0;
  assign n_wr             = push_fire ? (n_push - wr_skip) : '0;
  // Bypassed lanes never touch storage, so a bypass-pop removes nothing from the queue.
  assign n_pop            = (decode_valid_out & decode_ready_in & ~byp_act) ? q_cnt : '0;
  assign occupancy_out    = occ;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_lane
    fdq_in_lane #(.IW(IW), .PW(PW), .PTR_W(PTR_W), .FC_W(FC_W), .LANE(i)) u_lane (
      .fire    (push_fire),
      .n_push  (n_push),
      .wr_skip (wr_skip),
      .tail    (tail),
      .pc_base (fetch_pc_in),
      .we      (lane_we[i]),
      .waddr   (lane_addr[i]),
      .pc      (lane_pc[i])
    );
  end

  for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_slot
    entry_t q_ent;
    assign q_ent = mem[head + PTR_W'(j)];
    if (j < IN_WIDTH) begin : g_byp
      assign slot[j] = byp_act ? {fetch_instrs_in[j*IW +: IW], lane_pc[j]} : q_ent;
    end else begin : g_nobyp
      assign slot[j] = q_ent;
    end
    assign decode_instrs_out[j*IW +: IW] = slot[j].instr;
    assign decode_pcs_out[j*PW +: PW]    = slot[j].pc;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush_in) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PTR_W'(n_pop);
      tail <= tail + PTR_W'(n_wr);
      occ  <= occ + OCC_W'(n_wr) - OCC_W'(n_pop);
    end
  end

  // Storage is intentionally left unreset; head/tail/occ alone define validity.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < IN_WIDTH; i++)
      if (lane_we[i]) mem[lane_addr[i]] <= {fetch_instrs_in[i*IW +: IW], lane_pc[i]};
  end
endmodule
